// File: rtl/kbd_pkg.sv
// Shared types and constants for the keyboard cursor controller.
package kbd_pkg;

    localparam int COORD_W = 4;
    localparam int IDX_W   = 8;
    localparam int CNT_W   = 8;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOCK = 2'd1,
        ST_SHOT = 2'd2
    } state_e;

endpackage

// File: rtl/cursor_step.sv
// One-axis cursor step: clamps at the grid edges by default, wraps modulo SIZE
// when CURSOR_WRAP_EN is defined.
module cursor_step
    import kbd_pkg::*;
#(
    parameter int SIZE = 10
) (
    input  logic [COORD_W-1:0] pos,
    input  logic               dec,
    input  logic               inc,
    output logic [COORD_W-1:0] nxt
);

    localparam logic [COORD_W-1:0] LAST = COORD_W'(SIZE - 1);
    localparam logic [COORD_W-1:0] ONE  = COORD_W'(1);

    always_comb begin
        nxt = pos;
        if (dec) begin
`ifdef CURSOR_WRAP_EN
            nxt = (pos == '0) ? LAST : pos - ONE;
`else
            nxt = (pos == '0) ? pos : pos - ONE;
`endif
        end else if (inc) begin
`ifdef CURSOR_WRAP_EN
            nxt = (pos == LAST) ? '0 : pos + ONE;
`else
            nxt = (pos == LAST) ? pos : pos + ONE;
`endif
        end
    end

endmodule

// File: rtl/kbd_cursor_ctrl.sv
// Keyboard-driven cursor and shot request controller with fired-cell map and
// post-event lockout. Edge behaviour selected by CURSOR_WRAP_EN (see cursor_step).
//
// state   | meaning
// IDLE    | no shot pending, no lockout; key events accepted
// LOCK    | lockout counter running; key events discarded
// SHOT    | shot_valid asserted, waiting for shot_ready
module kbd_cursor_ctrl
    import kbd_pkg::*;
#(
    parameter int GRID_W   = 10,
    parameter int GRID_H   = 10,
    parameter int LOCK_CYC = 16
) (
    input  logic               sys_clk,
    input  logic               rst_n,
    input  logic               kbd_done,
    input  logic [1:0]         kbd_dir,
    input  logic               kbd_fire,
    input  logic               enable,
    input  logic               new_game,
    input  logic               shot_ready,
    output logic [COORD_W-1:0] cur_x,
    output logic [COORD_W-1:0] cur_y,
    output logic               shot_valid,
    output logic [COORD_W-1:0] shot_x,
    output logic [COORD_W-1:0] shot_y,
    output logic               dup_err
);

    localparam int                    MAP_BITS  = GRID_W * GRID_H;
    localparam logic [MAP_BITS-1:0]   MAP_ONE   = MAP_BITS'(1);
    localparam logic [CNT_W-1:0]      LOCK_LOAD = CNT_W'(LOCK_CYC - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     lock_cnt;
    logic [MAP_BITS-1:0]  fired_map;
    logic [IDX_W-1:0]     cell_idx;
    logic [MAP_BITS-1:0]  cell_mask;
    logic                 cell_fired;
    logic                 accept;
    logic                 do_move, do_shot, do_dup, load_lock;
    logic [COORD_W-1:0]   x_nxt, y_nxt;
    dir_e                 dir;

    assign dir        = dir_e'(kbd_dir);
    assign cell_idx   = IDX_W'(cur_y) * IDX_W'(GRID_W) + IDX_W'(cur_x);
    assign cell_mask  = MAP_ONE << cell_idx;
    assign cell_fired = |(fired_map & cell_mask);
    // new_game has priority, so it can never coincide with an accepted event
    assign accept     = (state_q == ST_IDLE) && enable && kbd_done && !new_game;
    assign shot_valid = (state_q == ST_SHOT);

    cursor_step #(.SIZE(GRID_W)) u_step_x (
        .pos (cur_x),
        .dec (do_move && (dir == DIR_LEFT)),
        .inc (do_move && (dir == DIR_RIGHT)),
        .nxt (x_nxt)
    );

    cursor_step #(.SIZE(GRID_H)) u_step_y (
        .pos (cur_y),
        .dec (do_move && (dir == DIR_UP)),
        .inc (do_move && (dir == DIR_DOWN)),
        .nxt (y_nxt)
    );

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        do_move   = 1'b0;
        do_shot   = 1'b0;
        do_dup    = 1'b0;
        load_lock = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!kbd_fire) begin
                        do_move   = 1'b1;
                        load_lock = 1'b1;
                        state_d   = ST_LOCK;
                    end else if (cell_fired) begin
                        do_dup    = 1'b1;
                        load_lock = 1'b1;
                        state_d   = ST_LOCK;
                    end else begin
                        do_shot   = 1'b1;
                        state_d   = ST_SHOT;
                    end
                end
            end
            ST_LOCK: begin
                if (new_game || lock_cnt == '0) state_d = ST_IDLE;
            end
            ST_SHOT: begin
                if (shot_ready) begin
                    load_lock = 1'b1;
                    state_d   = ST_LOCK;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_x     <= '0;
            cur_y     <= '0;
            shot_x    <= '0;
            shot_y    <= '0;
            dup_err   <= 1'b0;
            fired_map <= '0;
            lock_cnt  <= '0;
        end else begin
            dup_err <= do_dup;

            if (new_game) begin
                cur_x     <= '0;
                cur_y     <= '0;
                fired_map <= '0;
            end else if (do_move) begin
                cur_x <= x_nxt;
                cur_y <= y_nxt;
            end

            if (do_shot) begin
                fired_map <= fired_map | cell_mask;
                shot_x    <= cur_x;
                shot_y    <= cur_y;
            end

            if (load_lock)
                lock_cnt <= LOCK_LOAD;
            else if (new_game && state_q == ST_LOCK)
                lock_cnt <= '0;
            else if (state_q == ST_LOCK && lock_cnt != '0)
                lock_cnt <= lock_cnt - CNT_ONE;
        end
    end

endmodule
